dct_1d_pipe: RTL

DCT_1D_PIPE -- requirements
Module: dct_1d_pipe

---
 rtl/dct_1d_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dct_1d_pipe.sv
// dct_1d_pipe: 8-point integer DCT, 3-stage pipeline (butterfly, shift-add MAC, round/saturate)
module dct_1d_pipe #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 10,
    parameter int NCOEF = 4,
    parameter int FRAC  = 5,
    parameter int RND   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    input  logic                 in_dc_alt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 out_sat,
    output logic [2:0]           out_row,
    output logic                 out_last
);
    localparam int W = IN_W + 10;
    typedef logic signed [W-1:0] acc_t;
    localparam acc_t MAXV = acc_t'((1 << (OUT_W - 1)) - 1);
    localparam acc_t MINV = acc_t'(-(1 << (OUT_W - 1)));
    localparam logic [5:0] CA = 6'd45, CB = 6'd63, CC = 6'd59, CD = 6'd53;
    localparam logic [5:0] CE = 6'd36, CF = 6'd24, CG = 6'd12;

    // Constant multiply built from shifted partial products
    function automatic acc_t cmul(acc_t v, logic [5:0] c);
        acc_t p;
        p = '0;
        for (int i = 0; i < 6; i++)
            if (c[i]) p = p + (v <<< i);
        return p;
    endfunction

    // Arithmetic shift with optional round-half-away-from-zero
    function automatic acc_t rnd_sh(acc_t v, int sh);
        acc_t h;
        h = '0;
        if (RND != 0 && sh > 0) h = acc_t'(1) <<< (sh - 1);
        if (v[W-1] && |h) h = h - acc_t'(1);
        return (v + h) >>> sh;
    endfunction

    logic en;
    acc_t x [8];
    acc_t ev [4];
    acc_t e_d [4], o_d [4], e_q [4], o_q [4];
    acc_t s_d [8], s_q [8];
    acc_t y_d [8];
    logic v1_q, v2_q, dc1_q, dc2_q;
    logic out_valid_q, out_sat_q, sat_d;
    logic [8*OUT_W-1:0] out_data_q, out_d;
    logic [2:0] out_row_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_row   = out_row_q;
    assign out_last  = out_valid_q && (out_row_q == 3'd7);

    // Stage 1: first- and second-level butterfly on the sign-extended samples
    always_comb begin
        for (int n = 0; n < 8; n++)
            x[n] = acc_t'($signed(in_data[(8-n)*IN_W-1 -: IN_W]));
        for (int n = 0; n < 4; n++) begin
            ev[n]  = x[n] + x[7-n];
            o_d[n] = x[n] - x[7-n];
        end
        e_d[0] = (ev[0] + ev[3]) + (ev[1] + ev[2]);
        e_d[1] = (ev[0] + ev[3]) - (ev[1] + ev[2]);
        e_d[2] = ev[0] - ev[3];
        e_d[3] = ev[1] - ev[2];
    end

    // Stage 2: even and odd coefficient sums from the butterfly terms
    always_comb begin
        s_d[0] = cmul(e_q[0], CA);
        s_d[4] = cmul(e_q[1], CA);
        s_d[2] = cmul(e_q[2], CC) + cmul(e_q[3], CF);
        s_d[6] = cmul(e_q[2], CF) - cmul(e_q[3], CC);
        s_d[1] = cmul(o_q[0], CB) + cmul(o_q[1], CD) + cmul(o_q[2], CE) + cmul(o_q[3], CG);
        s_d[3] = cmul(o_q[0], CD) - cmul(o_q[1], CG) - cmul(o_q[2], CB) - cmul(o_q[3], CE);
        s_d[5] = cmul(o_q[0], CE) - cmul(o_q[1], CB) + cmul(o_q[2], CG) + cmul(o_q[3], CD);
        s_d[7] = cmul(o_q[0], CG) - cmul(o_q[1], CE) + cmul(o_q[2], CD) - cmul(o_q[3], CB);
    end

    // Stage 3: scale, round, clip and zero the coefficients that are not kept
    always_comb begin
        out_d = '0;
        sat_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            y_d[k] = rnd_sh(s_q[k], (k == 0 && dc2_q) ? FRAC + 2 : FRAC);
            if (k < NCOEF) begin
                sat_d = sat_d | (y_d[k] > MAXV) | (y_d[k] < MINV);
                out_d[(8-k)*OUT_W-1 -: OUT_W] = (y_d[k] > MAXV) ? MAXV[OUT_W-1:0] :
                                                (y_d[k] < MINV) ? MINV[OUT_W-1:0] :
                                                y_d[k][OUT_W-1:0];
            end
        end
    end

    // All stages advance together on the shared enable; row counts delivered beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= 3'd0;
        end else begin
            if (en) begin
                v1_q        <= in_valid;
                dc1_q       <= in_dc_alt;
                e_q         <= e_d;
                o_q         <= o_d;
                v2_q        <= v1_q;
                dc2_q       <= dc1_q;
                s_q         <= s_d;
                out_valid_q <= v2_q;
                out_data_q  <= out_d;
                out_sat_q   <= sat_d;
            end
            if (out_valid_q && out_ready) out_row_q <= out_row_q + 3'd1;
        end
    end
endmodule
